// File: rtl/nanorv32_irq_ctrl_pkg.sv
// Shared constants and types for the nanorv32 interrupt controller.
// Default source count, ID width and the controller state encoding.
package nanorv32_irq_ctrl_pkg;

    localparam int NANORV32_IRQ_NB     = 8;
    localparam int NANORV32_IRQ_ID_MSB = 2;

    typedef enum logic [1:0] {
        NANORV32_IRQC_IDLE    = 2'd0,
        NANORV32_IRQC_REQ     = 2'd1,
        NANORV32_IRQC_SERVICE = 2'd2
    } irqc_state_e;

endpackage

// File: rtl/nanorv32_irq_ctrl_if.sv
// Link between the interrupt controller (master) and the pipeline flow
// controller (slave).
interface nanorv32_irq_ctrl_if #(
    parameter int IRQ_ID_W = 3
);
    // irq is a level request held from IDLE->REQ until the cycle irq_ack is
    // sampled high; irq_id is stable for that whole window and through
    // service. irq_ack and reti_done are single-cycle pulses, and each one is
    // honoured only in the state that expects it (REQ and SERVICE).
    logic                irq;
    logic [IRQ_ID_W-1:0] irq_id;
    logic                irq_ack;
    logic                reti_done;
    logic                in_service;

    modport master (
        output irq, irq_id, in_service,
        input  irq_ack, reti_done
    );

    modport slave (
        input  irq, irq_id, in_service,
        output irq_ack, reti_done
    );
endinterface

// File: rtl/nanorv32_irq_sync.sv
// One-bit two-flop synchroniser with a delayed copy for rising-edge detect.
module nanorv32_irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s2,
    output logic rise
);
    logic s1;
    logic s2_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise = s2 & ~s2_d;
endmodule

// File: rtl/nanorv32_irq_ctrl.sv
// Multi-source interrupt controller: synchronise, latch, mask, pick the
// lowest-index eligible source and track it through service (no nesting).
module nanorv32_irq_ctrl
    import nanorv32_irq_ctrl_pkg::*;
#(
    parameter int NB_IRQ   = NANORV32_IRQ_NB,
    parameter int IRQ_ID_W = NANORV32_IRQ_ID_MSB + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NB_IRQ-1:0]   irq_src,
    input  logic [NB_IRQ-1:0]   irq_en,
    input  logic [NB_IRQ-1:0]   irq_edge,
    input  logic                sw_clr,
    input  logic [IRQ_ID_W-1:0] sw_clr_idx,
    output logic [NB_IRQ-1:0]   pending,
    output irqc_state_e         state_dbg,
    nanorv32_irq_ctrl_if.master fc
);

    logic [NB_IRQ-1:0]   s2;
    logic [NB_IRQ-1:0]   rise;
    logic [NB_IRQ-1:0]   clr;
    logic [NB_IRQ-1:0]   pending_nxt;
    logic [NB_IRQ-1:0]   eligible;
    logic [IRQ_ID_W-1:0] winner;
    irqc_state_e         state;
    logic                irq_q;
    logic [IRQ_ID_W-1:0] irq_id_q;
    logic                in_service_q;

    for (genvar g = 0; g < NB_IRQ; g++) begin : g_sync
        nanorv32_irq_sync u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (irq_src[g]),
            .s2    (s2[g]),
            .rise  (rise[g])
        );
    end

    // A fresh rise beats any clear in the same cycle so no event is lost;
    // level sources simply mirror the synchronised line.
    always_comb begin
        clr         = '0;
        pending_nxt = '0;
        for (int i = 0; i < NB_IRQ; i++) begin
            clr[i] = (fc.irq_ack && (state == NANORV32_IRQC_REQ) && (irq_id_q == IRQ_ID_W'(i)))
                   || (sw_clr && (sw_clr_idx == IRQ_ID_W'(i)));
            pending_nxt[i] = irq_edge[i] ? (rise[i] | (pending[i] & ~clr[i])) : s2[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    assign eligible = pending & irq_en;

    always_comb begin
        winner = '0;
        for (int i = NB_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = IRQ_ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= NANORV32_IRQC_IDLE;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            case (state)
                NANORV32_IRQC_IDLE: begin
                    if (eligible != '0) begin
                        state    <= NANORV32_IRQC_REQ;
                        irq_q    <= 1'b1;
                        irq_id_q <= winner;
                    end
                end
                NANORV32_IRQC_REQ: begin
                    if (fc.irq_ack) begin
                        state        <= NANORV32_IRQC_SERVICE;
                        irq_q        <= 1'b0;
                        in_service_q <= 1'b1;
                    end
                end
                NANORV32_IRQC_SERVICE: begin
                    if (fc.reti_done) begin
                        state        <= NANORV32_IRQC_IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= NANORV32_IRQC_IDLE;
                    irq_q        <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign fc.irq        = irq_q;
    assign fc.irq_id     = irq_id_q;
    assign fc.in_service = in_service_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_nanorv32_irq_ctrl.sv
// Bench for nanorv32_irq_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model.
module tb_nanorv32_irq_ctrl;
    import nanorv32_irq_ctrl_pkg::*;

    localparam int NB = 8;
    localparam int W  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] irq_src = '0;
    logic [NB-1:0] irq_en = '1;
    logic [NB-1:0] irq_edge = '1;
    logic          sw_clr = 1'b0;
    logic [W-1:0]  sw_clr_idx = '0;
    logic [NB-1:0] pending;
    irqc_state_e   state_dbg;

    nanorv32_irq_ctrl_if #(.IRQ_ID_W(W)) fc_if ();

    nanorv32_irq_ctrl #(.NB_IRQ(NB), .IRQ_ID_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_src    (irq_src),
        .irq_en     (irq_en),
        .irq_edge   (irq_edge),
        .sw_clr     (sw_clr),
        .sw_clr_idx (sw_clr_idx),
        .pending    (pending),
        .state_dbg  (state_dbg),
        .fc         (fc_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: delayed samples of the raw lines, the pending set,
    // and whether a request is outstanding or being serviced.
    logic [NB-1:0] m_d1, m_d2, m_d3, m_pend;
    bit            m_req, m_busy;
    int            m_id;

    function automatic void model_reset();
        m_d1 = '0; m_d2 = '0; m_d3 = '0; m_pend = '0;
        m_req = 0; m_busy = 0; m_id = 0;
    endfunction

    function automatic void model_step();
        logic [NB-1:0] rise, elig, nxt;
        bit clr;
        rise = m_d2 & ~m_d3;
        elig = m_pend & irq_en;
        for (int i = 0; i < NB; i++) begin
            clr = (fc_if.irq_ack && m_req && m_id == i) || (sw_clr && int'(sw_clr_idx) == i);
            if (irq_edge[i]) nxt[i] = rise[i] | (m_pend[i] & ~clr);
            else             nxt[i] = m_d2[i];
        end
        if (!m_req && !m_busy && elig != 0) begin
            m_req = 1;
            for (int i = NB - 1; i >= 0; i--) if (elig[i]) m_id = i;
        end else if (m_req && fc_if.irq_ack) begin
            m_req = 0; m_busy = 1;
        end else if (m_busy && fc_if.reti_done) begin
            m_busy = 0;
        end
        m_pend = nxt;
        m_d3 = m_d2; m_d2 = m_d1; m_d1 = irq_src;
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        irq_src = '0; irq_en = '1; irq_edge = '1; sw_clr = 1'b0; sw_clr_idx = '0;
        fc_if.irq_ack = 1'b0; fc_if.reti_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic pulse_ack();
        fc_if.irq_ack = 1'b1; cycle(); fc_if.irq_ack = 1'b0;
    endtask

    task automatic pulse_reti();
        fc_if.reti_done = 1'b1; cycle(); fc_if.reti_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        irq_src = '1;
        #3;
        checks++; if (fc_if.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", fc_if.irq); end
        checks++; if (fc_if.irq_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d want 0", fc_if.irq_id); end
        checks++; if (fc_if.in_service !== 1'b0) begin errors++; $display("FAIL reset_insvc got %b want 0", fc_if.in_service); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h want 00", pending); end
        checks++; if (state_dbg !== NANORV32_IRQC_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
        apply_reset();
    endtask

    task automatic test_latency();
        irq_src = 8'h08;
        cycles(2);
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL lat_pend_e1 got %h want 00", pending); end
        cycle();
        checks++; if (pending !== 8'h08) begin errors++; $display("FAIL lat_pend_e2 got %h want 08", pending); end
        checks++; if (fc_if.irq !== 1'b0) begin errors++; $display("FAIL lat_irq_e2 got %b want 0", fc_if.irq); end
        cycle();
        checks++; if (fc_if.irq !== 1'b1 || fc_if.irq_id !== 3'd3) begin
            errors++; $display("FAIL lat_irq_e3 got irq=%b id=%0d want irq=1 id=3", fc_if.irq, fc_if.irq_id); end
        pulse_ack();
        checks++; if (fc_if.irq !== 1'b0 || fc_if.in_service !== 1'b1 || pending !== 8'h00) begin
            errors++; $display("FAIL lat_ack got irq=%b insvc=%b pend=%h want 0 1 00", fc_if.irq, fc_if.in_service, pending); end
        pulse_reti();
        checks++; if (fc_if.in_service !== 1'b0 || state_dbg !== NANORV32_IRQC_IDLE) begin
            errors++; $display("FAIL lat_reti got insvc=%b state=%0d want 0 0", fc_if.in_service, state_dbg); end
        irq_src = '0; cycles(4);
    endtask

    task automatic test_priority();
        irq_src = 8'h24;
        cycles(4);
        checks++; if (fc_if.irq !== 1'b1 || fc_if.irq_id !== 3'd2) begin
            errors++; $display("FAIL prio_first got irq=%b id=%0d want 1 2", fc_if.irq, fc_if.irq_id); end
        pulse_ack();
        checks++; if (pending !== 8'h20) begin errors++; $display("FAIL prio_pend got %h want 20", pending); end
        pulse_reti();
        checks++; if (fc_if.irq !== 1'b0) begin errors++; $display("FAIL prio_gap got %b want 0", fc_if.irq); end
        cycle();
        checks++; if (fc_if.irq !== 1'b1 || fc_if.irq_id !== 3'd5) begin
            errors++; $display("FAIL prio_second got irq=%b id=%0d want 1 5", fc_if.irq, fc_if.irq_id); end
        pulse_ack(); pulse_reti();
        irq_src = '0; cycles(4);
    endtask

    task automatic test_frozen();
        irq_src = 8'h10;
        cycles(4);
        checks++; if (fc_if.irq !== 1'b1 || fc_if.irq_id !== 3'd4) begin
            errors++; $display("FAIL frz_req got irq=%b id=%0d want 1 4", fc_if.irq, fc_if.irq_id); end
        irq_src = 8'h11;
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++; if (fc_if.irq !== 1'b1 || fc_if.irq_id !== 3'd4) begin
                errors++; $display("FAIL frz_hold got irq=%b id=%0d want 1 4", fc_if.irq, fc_if.irq_id); end
        end
        pulse_ack();
        checks++; if (fc_if.irq_id !== 3'd4 || pending !== 8'h01) begin
            errors++; $display("FAIL frz_svc got id=%0d pend=%h want 4 01", fc_if.irq_id, pending); end
        pulse_reti(); cycle();
        checks++; if (fc_if.irq !== 1'b1 || fc_if.irq_id !== 3'd0) begin
            errors++; $display("FAIL frz_next got irq=%b id=%0d want 1 0", fc_if.irq, fc_if.irq_id); end
        pulse_ack(); pulse_reti();
        irq_src = '0; cycles(4);
    endtask

    task automatic test_ack_rise();
        irq_src = 8'h40; cycle();
        irq_src = 8'h00; cycle();
        irq_src = 8'h40; cycles(2);
        checks++; if (fc_if.irq !== 1'b1 || fc_if.irq_id !== 3'd6) begin
            errors++; $display("FAIL ackr_req got irq=%b id=%0d want 1 6", fc_if.irq, fc_if.irq_id); end
        pulse_ack();
        checks++; if (pending !== 8'h40 || fc_if.in_service !== 1'b1) begin
            errors++; $display("FAIL ackr_keep got pend=%h insvc=%b want 40 1", pending, fc_if.in_service); end
        pulse_reti(); cycle();
        checks++; if (fc_if.irq !== 1'b1 || fc_if.irq_id !== 3'd6) begin
            errors++; $display("FAIL ackr_again got irq=%b id=%0d want 1 6", fc_if.irq, fc_if.irq_id); end
        pulse_ack(); pulse_reti();
        irq_src = '0; cycles(4);
    endtask

    task automatic test_level();
        irq_src = 8'h80; cycles(4);
        checks++; if (fc_if.irq !== 1'b1 || fc_if.irq_id !== 3'd7) begin
            errors++; $display("FAIL lvl_req7 got irq=%b id=%0d want 1 7", fc_if.irq, fc_if.irq_id); end
        pulse_ack();
        irq_edge = 8'hFD; irq_src = 8'h82;
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++; if (fc_if.irq !== 1'b0) begin errors++; $display("FAIL lvl_svc_irq got %b want 0", fc_if.irq); end
        end
        checks++; if (pending !== 8'h02) begin errors++; $display("FAIL lvl_pend got %h want 02", pending); end
        pulse_reti();
        checks++; if (fc_if.irq !== 1'b0 || fc_if.in_service !== 1'b0) begin
            errors++; $display("FAIL lvl_reti got irq=%b insvc=%b want 0 0", fc_if.irq, fc_if.in_service); end
        cycle();
        checks++; if (fc_if.irq !== 1'b1 || fc_if.irq_id !== 3'd1) begin
            errors++; $display("FAIL lvl_req1 got irq=%b id=%0d want 1 1", fc_if.irq, fc_if.irq_id); end
        pulse_ack();
        checks++; if (pending !== 8'h02) begin errors++; $display("FAIL lvl_ack_noclr got %h want 02", pending); end
        irq_src = 8'h00; cycles(3);
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL lvl_drop got %h want 00", pending); end
        pulse_reti();
        irq_en = 8'hFD; irq_src = 8'h02;
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++; if (fc_if.irq !== 1'b0) begin errors++; $display("FAIL lvl_masked got %b want 0", fc_if.irq); end
        end
        checks++; if (pending !== 8'h02) begin errors++; $display("FAIL lvl_masked_pend got %h want 02", pending); end
        irq_src = '0; cycles(4);
        irq_en = '1; irq_edge = '1; cycles(2);
    endtask

    task automatic test_sw_clr();
        irq_en = 8'hFB; irq_src = 8'h04; cycles(4);
        checks++; if (fc_if.irq !== 1'b0 || pending !== 8'h04) begin
            errors++; $display("FAIL swc_capture got irq=%b pend=%h want 0 04", fc_if.irq, pending); end
        sw_clr = 1'b1; sw_clr_idx = 3'd2; cycle(); sw_clr = 1'b0;
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL swc_clear got %h want 00", pending); end
        irq_src = 8'h00; cycles(2);
        irq_src = 8'h04; cycles(2);
        sw_clr = 1'b1; cycle(); sw_clr = 1'b0;
        checks++; if (pending !== 8'h04) begin errors++; $display("FAIL swc_set_wins got %h want 04", pending); end
        sw_clr = 1'b1; cycle(); sw_clr = 1'b0;
        irq_en = '1; cycles(2);
        checks++; if (fc_if.irq !== 1'b0 || pending !== 8'h00) begin
            errors++; $display("FAIL swc_after got irq=%b pend=%h want 0 00", fc_if.irq, pending); end
        irq_src = '0; cycles(4);
    endtask

    task automatic test_reset_mid();
        irq_src = 8'h81; cycles(4);
        pulse_ack();
        irq_src = 8'h80; cycles(2);
        irq_src = 8'h81; cycles(3);
        checks++; if (pending !== 8'h81 || state_dbg !== NANORV32_IRQC_SERVICE) begin
            errors++; $display("FAIL rmid_setup got pend=%h state=%0d want 81 2", pending, state_dbg); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (fc_if.irq !== 1'b0 || fc_if.in_service !== 1'b0 || pending !== 8'h00) begin
            errors++; $display("FAIL rmid_async got irq=%b insvc=%b pend=%h want 0 0 00", fc_if.irq, fc_if.in_service, pending); end
        irq_src = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            checks++; if (fc_if.irq !== 1'b0 || pending !== 8'h00) begin
                errors++; $display("FAIL rmid_after got irq=%b pend=%h want 0 00", fc_if.irq, pending); end
        end
    endtask

    task automatic test_random();
        int shown = 0;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            if (n % 60 == 0) begin
                irq_edge = 8'($urandom);
                irq_en   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            end
            for (int i = 0; i < NB; i++) if ($urandom_range(0, 7) == 0) irq_src[i] = ~irq_src[i];
            fc_if.irq_ack   = m_req  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            fc_if.reti_done = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            sw_clr     = ($urandom_range(0, 7) == 0);
            sw_clr_idx = 3'($urandom_range(0, 7));
            cycle();
            checks++;
            if (fc_if.irq !== m_req || fc_if.in_service !== m_busy
                || int'(fc_if.irq_id) != m_id || pending !== m_pend) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_cycle%0d got irq=%b insvc=%b id=%0d pend=%h want %b %b %0d %h",
                             n, fc_if.irq, fc_if.in_service, fc_if.irq_id, pending, m_req, m_busy, m_id, m_pend);
                end
            end
        end
        fc_if.irq_ack = 1'b0; fc_if.reti_done = 1'b0; sw_clr = 1'b0;
    endtask

    initial begin
        fc_if.irq_ack = 1'b0;
        fc_if.reti_done = 1'b0;
        model_reset();
        test_reset();
        test_latency();
        test_priority();
        test_frozen();
        test_ack_rise();
        test_level();
        test_sw_clr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
